instr_fetch_decode: RTL and testbench

//  Reader side of program_memory: drives the ROM address bus, fetches 1- or 2-byte instructions,

---
 rtl/instr_fetch_decode.sv | 236 +++++++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: walks program ROM, assembles 1- or 2-byte instructions,
// resolves BRA/BHI/BEQ locally and presents decoded fields to the execute stage.
module instr_fetch_decode #(
  parameter logic [7:0] RESET_PC     = 8'd0,
  parameter logic [7:0] FLAG_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pc_addr,
  input  logic [7:0] rom_data,
  input  logic       flags_valid,
  input  logic       flag_hi,
  input  logic       flag_eq,
  output logic       dec_valid,
  input  logic       dec_ready,
  output logic [5:0] dec_opcode,
  output logic [1:0] dec_rd,
  output logic [1:0] dec_rs,
  output logic [7:0] dec_imm,
  output logic [7:0] dec_pc,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_F1      = 3'd1,
    S_F2      = 3'd2,
    S_ISSUE   = 3'd3,
    S_BR_WAIT = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD        = 6'b000000;
  localparam logic [5:0] OP_SUB        = 6'b000001;
  localparam logic [5:0] OP_MUL        = 6'b000010;
  localparam logic [5:0] OP_MOV        = 6'b000100;
  localparam logic [5:0] OP_NOP        = 6'b000111;
  localparam logic [5:0] OP_LD_IMM     = 6'b100000;
  localparam logic [5:0] OP_LD_MEM     = 6'b100001;
  localparam logic [5:0] OP_CMP        = 6'b100011;
  localparam logic [5:0] OP_DEC        = 6'b100101;
  localparam logic [5:0] OP_INPUT      = 6'b100110;
  localparam logic [5:0] OP_OUTPUT     = 6'b100111;
  localparam logic [5:0] OP_BRA        = 6'b101010;
  localparam logic [5:0] OP_BHI        = 6'b101100;
  localparam logic [5:0] OP_BEQ        = 6'b101101;
  localparam logic [5:0] OP_LD_MEM_REG = 6'b110000;

  // Short ops carry a 4-bit opcode in the top nibble, long ops a 6-bit one.
  function automatic logic [5:0] op_of(input logic [7:0] b);
    if (b[7]) begin
      return b[7:2];
    end else begin
      return {2'b00, b[7:4]};
    end
  endfunction

  function automatic logic is_two_byte(input logic [5:0] op);
    case (op)
      OP_LD_IMM, OP_LD_MEM, OP_CMP, OP_BRA, OP_BHI, OP_BEQ: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_one_byte(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_NOP,
      OP_DEC, OP_INPUT, OP_OUTPUT, OP_LD_MEM_REG: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  state_t     state_r, state_s;
  logic [7:0] pc_r, pc_s;
  logic [7:0] instr_r, instr_s;
  logic [7:0] ipc_r, ipc_s;
  logic [7:0] tgt_r, tgt_s;
  logic [7:0] cnt_r, cnt_s;
  logic       valid_r, valid_s;
  logic [5:0] opcode_r, opcode_s;
  logic [1:0] rd_r, rd_s;
  logic [1:0] rs_r, rs_s;
  logic [7:0] imm_r, imm_s;
  logic [7:0] dpc_r, dpc_s;
  logic       illegal_r, illegal_s;

  logic [5:0] op_fetch_s;
  logic [5:0] op_held_s;
  logic       taken_s;

  assign op_fetch_s = op_of(rom_data);
  assign op_held_s  = op_of(instr_r);
  assign taken_s    = (op_held_s == OP_BHI) ? flag_hi : flag_eq;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    instr_s   = instr_r;
    ipc_s     = ipc_r;
    tgt_s     = tgt_r;
    cnt_s     = cnt_r;
    valid_s   = valid_r;
    opcode_s  = opcode_r;
    rd_s      = rd_r;
    rs_s      = rs_r;
    imm_s     = imm_r;
    dpc_s     = dpc_r;
    illegal_s = 1'b0;

    case (state_r)
      S_HOLD: begin
        state_s = S_F1;
      end

      S_F1: begin
        instr_s = rom_data;
        ipc_s   = pc_r;
        pc_s    = pc_r + 8'd1;
        if (is_two_byte(op_fetch_s)) begin
          state_s = S_F2;
        end else begin
          state_s = S_ISSUE;
          valid_s = 1'b1;
          imm_s   = 8'd0;
          dpc_s   = pc_r;
          if (is_legal_one_byte(op_fetch_s)) begin
            opcode_s = op_fetch_s;
            rd_s     = rom_data[7] ? rom_data[1:0] : rom_data[3:2];
            rs_s     = rom_data[7] ? 2'd0 : rom_data[1:0];
          end else begin
            // Unknown encodings flow downstream as a harmless NOP.
            opcode_s  = OP_NOP;
            rd_s      = 2'd0;
            rs_s      = 2'd0;
            illegal_s = 1'b1;
          end
        end
      end

      S_F2: begin
        pc_s = pc_r + 8'd1;
        if (op_held_s == OP_BRA) begin
          pc_s    = rom_data;
          state_s = S_F1;
        end else if ((op_held_s == OP_BHI) || (op_held_s == OP_BEQ)) begin
          tgt_s   = rom_data;
          cnt_s   = 8'd0;
          state_s = S_BR_WAIT;
        end else begin
          state_s  = S_ISSUE;
          valid_s  = 1'b1;
          opcode_s = op_held_s;
          rd_s     = instr_r[1:0];
          rs_s     = 2'd0;
          imm_s    = rom_data;
          dpc_s    = ipc_r;
        end
      end

      S_ISSUE: begin
        if (dec_ready) begin
          valid_s = 1'b0;
          state_s = S_F1;
        end else begin
          state_s = S_ISSUE;
        end
      end

      S_BR_WAIT: begin
        if (flags_valid) begin
          if (taken_s) begin
            pc_s = tgt_r;
          end else begin
            pc_s = pc_r;
          end
          cnt_s   = 8'd0;
          state_s = S_F1;
        end else if ((FLAG_TIMEOUT != 8'd0) && (cnt_r == (FLAG_TIMEOUT - 8'd1))) begin
          // Flags never arrived: report it and fall through to the next instruction.
          illegal_s = 1'b1;
          cnt_s     = 8'd0;
          state_s   = S_F1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      default: begin
        state_s = S_HOLD;
      end
    endcase
  end

  // State register; the low reset level also discards any pending instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_HOLD;
      pc_r      <= RESET_PC;
      instr_r   <= 8'd0;
      ipc_r     <= 8'd0;
      tgt_r     <= 8'd0;
      cnt_r     <= 8'd0;
      valid_r   <= 1'b0;
      opcode_r  <= 6'd0;
      rd_r      <= 2'd0;
      rs_r      <= 2'd0;
      imm_r     <= 8'd0;
      dpc_r     <= 8'd0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      ipc_r     <= ipc_s;
      tgt_r     <= tgt_s;
      cnt_r     <= cnt_s;
      valid_r   <= valid_s;
      opcode_r  <= opcode_s;
      rd_r      <= rd_s;
      rs_r      <= rs_s;
      imm_r     <= imm_s;
      dpc_r     <= dpc_s;
      illegal_r <= illegal_s;
    end
  end

  assign pc_addr    = pc_r;
  assign dec_valid  = valid_r;
  assign dec_opcode = opcode_r;
  assign dec_rd     = rd_r;
  assign dec_rs     = rs_r;
  assign dec_imm    = imm_r;
  assign dec_pc     = dpc_r;
  assign illegal    = illegal_r;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: ROM model, per-scenario tasks and
// a scoreboard of expected issued instructions {opcode, rd, rs, imm, pc}.
module tb_instr_fetch_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_addr;
  logic [7:0] rom_data;
  logic       flags_valid, flag_hi, flag_eq;
  logic       dec_valid, dec_ready;
  logic [5:0] dec_opcode;
  logic [1:0] dec_rd, dec_rs;
  logic [7:0] dec_imm, dec_pc;
  logic       illegal;

  logic [7:0]  rom [256];
  logic [25:0] sb [$];
  logic [25:0] obs;
  logic [25:0] exp_v;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[pc_addr];
  assign obs = {dec_opcode, dec_rd, dec_rs, dec_imm, dec_pc};

  instr_fetch_decode #(.RESET_PC(8'd0), .FLAG_TIMEOUT(8'd255)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .rom_data(rom_data),
    .flags_valid(flags_valid), .flag_hi(flag_hi), .flag_eq(flag_eq),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_imm(dec_imm), .dec_pc(dec_pc),
    .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset low with a NOP-filled ROM and quiet inputs.
  task automatic do_reset();
    reset = 1'b0;
    dec_ready = 1'b0;
    flags_valid = 1'b0;
    flag_hi = 1'b0;
    flag_eq = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h70;
    sb.delete();
    tick();
    tick();
  endtask

  task automatic wait_issue(input int budget, output bit ok);
    int n = 0;
    while (!dec_valid && n < budget) begin
      tick();
      n++;
    end
    ok = dec_valid;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({pc_addr, dec_valid, illegal, obs} !== {8'd0, 1'b0, 1'b0, 26'd0}) begin
      failures++;
      $display("FAIL reset_state got pc=%h v=%b ill=%b f=%h exp pc=00 v=0 ill=0 f=0",
               pc_addr, dec_valid, illegal, obs);
    end
  endtask

  task automatic test_ld_imm_then_sub();
    do_reset();
    rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h1B;
    sb.push_back({6'b100000, 2'd0, 2'd0, 8'h05, 8'h00});
    sb.push_back({6'b000001, 2'd2, 2'd3, 8'h00, 8'h02});
    reset = 1'b1;
    dec_ready = 1'b1;
    tick();
    checks++;
    if ({pc_addr, dec_valid} !== {8'd0, 1'b0}) begin
      failures++;
      $display("FAIL t1_first_fetch got pc=%h v=%b exp pc=00 v=0", pc_addr, dec_valid);
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dec_valid !== 1'b1) begin
        failures++;
        $display("FAIL t1_latency_%0d got valid=%b exp 1", k, dec_valid);
      end
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL t1_issue_%0d got=%h exp=%h", k, obs, exp_v);
      end
      tick();
      if (k == 0) begin
        checks++;
        if ({pc_addr, dec_valid} !== {8'd2, 1'b0}) begin
          failures++;
          $display("FAIL t1_refetch got pc=%h v=%b exp pc=02 v=0", pc_addr, dec_valid);
        end
        tick();
      end
    end
  endtask

  task automatic test_bra();
    logic [7:0] exp_pc [3];
    bit ok;
    exp_pc[0] = 8'd0; exp_pc[1] = 8'd1; exp_pc[2] = 8'd16;
    do_reset();
    rom[0] = 8'hA8; rom[1] = 8'd16; rom[16] = 8'h0B;
    sb.push_back({6'b000000, 2'd2, 2'd3, 8'h00, 8'd16});
    reset = 1'b1;
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({pc_addr, dec_valid} !== {exp_pc[k], 1'b0}) begin
        failures++;
        $display("FAIL bra_seq_%0d got pc=%h v=%b exp pc=%h v=0", k, pc_addr, dec_valid, exp_pc[k]);
      end
    end
    wait_issue(4, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL bra_issue got timeout exp issue");
    end else begin
      exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL bra_issue got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_bhi();
    bit ok;
    for (int t = 1; t >= 0; t--) begin
      do_reset();
      rom[0] = 8'hB0; rom[1] = 8'd37; rom[2] = 8'h27; rom[37] = 8'h14;
      if (t == 1) sb.push_back({6'b000001, 2'd1, 2'd0, 8'h00, 8'd37});
      else        sb.push_back({6'b000010, 2'd1, 2'd3, 8'h00, 8'd2});
      reset = 1'b1;
      dec_ready = 1'b1;
      tick(); tick(); tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({pc_addr, dec_valid} !== {8'd2, 1'b0}) begin
          failures++;
          $display("FAIL bhi_wait_%0d_%0d got pc=%h v=%b exp pc=02 v=0", t, k, pc_addr, dec_valid);
        end
        tick();
      end
      flags_valid = 1'b1;
      flag_hi = (t == 1);
      flag_eq = (t == 0);
      tick();
      flags_valid = 1'b0;
      flag_hi = 1'b0;
      flag_eq = 1'b0;
      checks++;
      if (pc_addr !== ((t == 1) ? 8'd37 : 8'd2)) begin
        failures++;
        $display("FAIL bhi_pc_%0d got pc=%h exp %h", t, pc_addr, (t == 1) ? 8'd37 : 8'd2);
      end
      wait_issue(4, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL bhi_issue_%0d got timeout exp issue", t);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL bhi_issue_%0d got=%h exp=%h", t, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    rom[0] = 8'h0B; rom[1] = 8'h14;
    sb.push_back({6'b000000, 2'd2, 2'd3, 8'h00, 8'd0});
    sb.push_back({6'b000001, 2'd1, 2'd0, 8'h00, 8'd1});
    reset = 1'b1;
    tick();
    tick();
    exp_v = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({dec_valid, pc_addr, obs} !== {1'b1, 8'd1, exp_v}) begin
        failures++;
        $display("FAIL stall_%0d got v=%b pc=%h f=%h exp v=1 pc=01 f=%h", k, dec_valid, pc_addr, obs, exp_v);
      end
      tick();
    end
    dec_ready = 1'b1;
    tick();
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept got valid=%b exp 0", dec_valid);
    end
    wait_issue(4, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL stall_next got timeout exp issue");
    end else begin
      exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_next got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    rom[0] = 8'hFC;
    sb.push_back({6'b000111, 2'd0, 2'd0, 8'h00, 8'd0});
    reset = 1'b1;
    dec_ready = 1'b1;
    tick();
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({illegal, dec_valid, obs} !== {1'b1, 1'b1, exp_v}) begin
      failures++;
      $display("FAIL illegal_issue got ill=%b v=%b f=%h exp ill=1 v=1 f=%h", illegal, dec_valid, obs, exp_v);
    end
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse got ill=%b exp 0", illegal);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit ok;
    do_reset();
    rom[0] = 8'hB4; rom[1] = 8'd40; rom[2] = 8'h0B;
    sb.push_back({6'b000000, 2'd2, 2'd3, 8'h00, 8'd2});
    reset = 1'b1;
    dec_ready = 1'b1;
    tick(); tick(); tick();
    while (!illegal && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if ({n, pc_addr, dec_valid} !== {32'd255, 8'd2, 1'b0}) begin
      failures++;
      $display("FAIL timeout got cycles=%0d pc=%h v=%b exp cycles=255 pc=02 v=0", n, pc_addr, dec_valid);
    end
    wait_issue(4, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL timeout_issue got timeout exp issue");
    end else begin
      exp_v = sb.pop_front();
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL timeout_issue got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'd0; exp_pc[1] = 8'd1; exp_pc[2] = 8'd255; exp_pc[3] = 8'd0;
    do_reset();
    rom[0] = 8'hA8; rom[1] = 8'hFF; rom[255] = 8'h80;
    sb.push_back({6'b100000, 2'd0, 2'd0, 8'hA8, 8'hFF});
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pc_addr !== exp_pc[k]) begin
        failures++;
        $display("FAIL wrap_seq_%0d got pc=%h exp %h", k, pc_addr, exp_pc[k]);
      end
    end
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({dec_valid, pc_addr, obs} !== {1'b1, 8'd1, exp_v}) begin
      failures++;
      $display("FAIL wrap_issue got v=%b pc=%h f=%h exp v=1 pc=01 f=%h", dec_valid, pc_addr, obs, exp_v);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++;
    if ({dec_valid, pc_addr} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL wrap_next got v=%b pc=%h exp v=0 pc=01", dec_valid, pc_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({dec_valid, pc_addr, illegal, obs} !== {1'b0, 8'd0, 1'b0, 26'd0}) begin
      failures++;
      $display("FAIL mid_issue_reset got v=%b pc=%h ill=%b f=%h exp all zero", dec_valid, pc_addr, illegal, obs);
    end
  endtask

  initial begin
    test_reset();
    test_ld_imm_then_sub();
    test_bra();
    test_bhi();
    test_stall();
    test_illegal();
    test_timeout();
    test_wrap_and_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
